xillybus_loopback_fifo32: RTL and testbench

User-side responder for the Xillybus 32-bit stream pair: it accepts words the core pushes on the `user_w_write_32` port and returns them in order on the `user_r_read_32` port. It sits in the user application region next to the core, on the core's bus clock. It presents the standard, non-first-word-fall-through FIFO handshake the core expects. It also generates end-of-file toward the host when the writing file is closed.

---
 rtl/xillybus_loopback_fifo32.sv | 75 +++++++
 tb/tb_xillybus_loopback_fifo32.sv | 131 +++++++++++++
 2 files changed

// File: rtl/xillybus_loopback_fifo32.sv
// xillybus_loopback_fifo32: 32-bit write-to-read loopback FIFO for the Xillybus core.
// Define XILLY_LOOPBACK_EOF_EN to generate end-of-file when the write file closes.
module xillybus_loopback_fifo32 #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  bus_clk,
    input  logic                  bus_rst,
    input  logic                  user_w_write_32_wren,
    input  logic [31:0]           user_w_write_32_data,
    input  logic                  user_w_write_32_open,
    output logic                  user_w_write_32_full,
    input  logic                  user_r_read_32_rden,
    input  logic                  user_r_read_32_open,
    output logic [31:0]           user_r_read_32_data,
    output logic                  user_r_read_32_empty,
    output logic                  user_r_read_32_eof,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  overflow_err
);
    localparam logic [DEPTH_LOG2:0] full_cnt = {1'b1, {DEPTH_LOG2{1'b0}}};
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wp, rp;
    logic [DEPTH_LOG2:0]   cnt;
    logic                  wr_ok, rd_ok, flush;
    assign user_w_write_32_full  = cnt == full_cnt;
    assign user_r_read_32_empty  = cnt == '0;
    assign fill_level            = cnt;
    assign wr_ok = user_w_write_32_wren && !user_w_write_32_full;
    assign rd_ok = user_r_read_32_rden && !user_r_read_32_empty;
    assign flush = !user_w_write_32_open && !user_r_read_32_open;
    // RAM kept free of reset so it maps onto block memory
    always_ff @(posedge bus_clk) begin
        if (wr_ok && !flush) mem[wp] <= user_w_write_32_data;
    end
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            wp                  <= '0;
            rp                  <= '0;
            cnt                 <= '0;
            user_r_read_32_data <= '0;
            overflow_err        <= 1'b0;
        end else begin
            if (user_w_write_32_wren && user_w_write_32_full) overflow_err <= 1'b1;
            if (flush) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (wr_ok) wp <= wp + 1'b1;
                if (rd_ok) begin
                    rp                  <= rp + 1'b1;
                    user_r_read_32_data <= mem[rp];
                end
                cnt <= (wr_ok && !rd_ok) ? cnt + 1'b1 :
                       (rd_ok && !wr_ok) ? cnt - 1'b1 : cnt;
            end
        end
    end
`ifdef XILLY_LOOPBACK_EOF_EN
    logic w_open_q, eof_pend;
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            w_open_q <= 1'b0;
            eof_pend <= 1'b0;
        end else begin
            w_open_q <= user_w_write_32_open;
            eof_pend <= (!user_r_read_32_open || (user_w_write_32_open && !w_open_q)) ? 1'b0 :
                        (!user_w_write_32_open && w_open_q) ? 1'b1 : eof_pend;
        end
    end
    assign user_r_read_32_eof = eof_pend && user_r_read_32_empty;
`else
    assign user_r_read_32_eof = 1'b0;
`endif
endmodule

// File: tb/tb_xillybus_loopback_fifo32.sv
// tb_xillybus_loopback_fifo32: directed and random checks of the loopback FIFO against a queue model.
module tb_xillybus_loopback_fifo32;
    localparam int DL = 4;
    localparam int DEPTH = 1 << DL;
    logic          clk = 1'b0;
    logic          rst, wren, wopen, rden, ropen;
    logic [31:0]   wdata;
    logic          full, empty, eof, ovf;
    logic [31:0]   rdata;
    logic [DL:0]   fill;
    int            checks = 0;
    int            errors = 0;
    logic [31:0]   q[$];
    logic [31:0]   m_data;
    logic          m_ovf, m_wq, m_pend;

    always #5 clk = ~clk;

    xillybus_loopback_fifo32 #(.DEPTH_LOG2(DL)) dut (
        .bus_clk(clk),
        .bus_rst(rst),
        .user_w_write_32_wren(wren),
        .user_w_write_32_data(wdata),
        .user_w_write_32_open(wopen),
        .user_w_write_32_full(full),
        .user_r_read_32_rden(rden),
        .user_r_read_32_open(ropen),
        .user_r_read_32_data(rdata),
        .user_r_read_32_empty(empty),
        .user_r_read_32_eof(eof),
        .fill_level(fill),
        .overflow_err(ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit mfull, mempty, exp_eof;
        if (rst) begin
            q.delete();
            m_data = '0;
            m_ovf  = 1'b0;
            m_wq   = 1'b0;
            m_pend = 1'b0;
            return;
        end
        mfull  = q.size() == DEPTH;
        mempty = q.size() == 0;
        if (wren && mfull) m_ovf = 1'b1;
        if (!wopen && !ropen) q.delete();
        else begin
            if (rden && !mempty) m_data = q.pop_front();
            if (wren && !mfull) q.push_back(wdata);
        end
        if (!ropen || (wopen && !m_wq)) m_pend = 1'b0;
        else if (!wopen && m_wq) m_pend = 1'b1;
        m_wq = wopen;
    endtask

    task automatic step(input logic r, input logic we, input logic re, input logic wo,
                        input logic ro, input logic [31:0] d);
        logic exp_eof;
        rst = r; wren = we; rden = re; wopen = wo; ropen = ro; wdata = d;
        @(posedge clk);
        model_edge();
        #1;
`ifdef XILLY_LOOPBACK_EOF_EN
        exp_eof = m_pend && q.size() == 0;
`else
        exp_eof = 1'b0;
`endif
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("fill_level", 32'(fill), 32'(q.size()));
        check("data", rdata, m_data);
        check("overflow_err", 32'(ovf), 32'(m_ovf));
        check("eof", 32'(eof), 32'(exp_eof));
    endtask

    initial begin
        rst = 1'b1; wren = 1'b0; rden = 1'b0; wopen = 1'b1; ropen = 1'b1; wdata = '0;
        step(1, 0, 0, 1, 1, 0);
        step(1, 1, 1, 1, 1, 32'hdead);
        step(0, 0, 0, 1, 1, 0);
        // ordering: 16 words in, 16 out
        for (int i = 1; i <= 16; i++) step(0, 1, 0, 1, 1, 32'(i));
        for (int i = 0; i < 16; i++) step(0, 0, 1, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        // fill past capacity
        for (int i = 0; i < 17; i++) step(0, 1, 0, 1, 1, 32'h100 + 32'(i));
        for (int i = 0; i < 16; i++) step(0, 0, 1, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        // simultaneous access at cnt=5, then at cnt=0
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 1, 32'h200 + 32'(i));
        for (int i = 0; i < 10; i++) step(0, 1, 1, 1, 1, 32'h300 + 32'(i));
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1, 0);
        step(0, 1, 1, 1, 1, 32'h400);
        step(0, 0, 1, 1, 1, 0);
        // simultaneous access when full: only the read wins
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 1, 1, 32'h500 + 32'(i));
        step(0, 1, 1, 1, 1, 32'h5ff);
        step(1, 0, 0, 1, 1, 0);
        // wrap-around with a reader three cycles behind
        for (int i = 0; i < 103; i++) step(0, i < 100, i >= 3, 1, 1, 32'h1000 + 32'(i));
        // eof after the write file closes
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 1, 32'h600 + 32'(i));
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        // flush with both files closed
        for (int i = 0; i < 7; i++) step(0, 1, 0, 1, 1, 32'h700 + 32'(i));
        step(0, 1, 1, 0, 0, 32'h7ff);
        step(0, 0, 1, 1, 1, 0);
        // reset mid-stream
        for (int i = 0; i < 5; i++) step(0, 1, i > 1, 1, 1, 32'h800 + 32'(i));
        step(1, 1, 1, 1, 1, 32'h8ff);
        step(0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 29) != 0, $urandom_range(0, 39) != 0, $urandom);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
